// File: rtl/dds_pkg.sv
// Shared types and constants for the two-channel DDS LUT sequencer.
package dds_pkg;

    localparam int unsigned DEF_PHASE_W = 24;
    localparam int unsigned DEF_ADDR_W  = 8;
    localparam int unsigned DEF_DATA_W  = 8;

    localparam logic CH_A = 1'b0;
    localparam logic CH_B = 1'b1;

    typedef enum logic [2:0] {IDLE, ACC, RD_A, RD_B, CAP} state_e;

endpackage

// File: rtl/dds_phase_acc.sv
// One DDS channel: tuning-word register plus phase accumulator.
// With DDS_PHASE_SYNC_EN defined, an advance can restart the phase from zero.
module dds_phase_acc #(
    parameter int unsigned PHASE_W = 24
) (
    input  logic               Fg_CLK,
    input  logic               RESETn,
    input  logic               i_load,
    input  logic [PHASE_W-1:0] i_tune,
    input  logic               i_adv,
`ifdef DDS_PHASE_SYNC_EN
    input  logic               i_sync,
`endif
    output logic [PHASE_W-1:0] o_phase
);

    logic [PHASE_W-1:0] r_tune;
    logic [PHASE_W-1:0] r_phase;
    logic [PHASE_W-1:0] w_tune_eff;
    logic [PHASE_W-1:0] w_base;

    // A word loaded on the advance cycle takes effect in that same accumulation.
    assign w_tune_eff = i_load ? i_tune : r_tune;
`ifdef DDS_PHASE_SYNC_EN
    assign w_base = i_sync ? '0 : r_phase;
`else
    assign w_base = r_phase;
`endif

    always_ff @(posedge Fg_CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_tune  <= '0;
            r_phase <= '0;
        end else begin
            if (i_load) r_tune <= i_tune;
            if (i_adv)  r_phase <= w_base + w_tune_eff;
        end
    end

    assign o_phase = r_phase;

endmodule

// File: rtl/dds_lut_sched.sv
// Two-channel DDS sequencer sharing one synchronous LUT; config lands on sample boundaries.
// Optional phase-sync input is enabled by defining DDS_PHASE_SYNC_EN.
module dds_lut_sched
    import dds_pkg::*;
#(
    parameter int unsigned PHASE_W = DEF_PHASE_W,
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned DATA_W  = DEF_DATA_W
) (
    input  logic               Fg_CLK,
    input  logic               RESETn,
    input  logic               Ready,
    input  logic               Enable,
    input  logic               CfgValid,
    input  logic               CfgChan,
    input  logic [PHASE_W-1:0] CfgTuning,
    output logic               CfgReady,
    input  logic               OvrClr,
`ifdef DDS_PHASE_SYNC_EN
    input  logic               PhaseSync,
`endif
    output logic               LutRd,
    output logic [ADDR_W-1:0]  LutAddr,
    input  logic [DATA_W-1:0]  LutData,
    output logic [DATA_W-1:0]  ChA_Data,
    output logic [DATA_W-1:0]  ChB_Data,
    output logic               SampleValid,
    output logic               Busy,
    output logic               Overrun
);

    state_e             r_state, w_state_nxt;
    logic               w_strobe, w_acc, w_cfg_xfer, w_load_a, w_load_b, w_sync;
    logic               r_pend, r_pend_chan, r_apply;
    logic [PHASE_W-1:0] r_pend_word;
    logic [PHASE_W-1:0] w_phase_a, w_phase_b;
    logic [DATA_W-1:0]  r_shadow, r_cha, r_chb;
    logic               r_sv, r_ovr;

    assign w_strobe   = Ready & Enable;
    assign w_acc      = (r_state == ACC);
    assign w_cfg_xfer = CfgValid & ~r_pend;
    // Only a word that was pending before this sequence started gets applied.
    assign w_load_a   = w_acc & r_apply & (r_pend_chan == CH_A);
    assign w_load_b   = w_acc & r_apply & (r_pend_chan == CH_B);

    always_ff @(posedge Fg_CLK or negedge RESETn) begin
        if (!RESETn) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (w_strobe) w_state_nxt = ACC;
            ACC:     w_state_nxt = RD_A;
            RD_A:    w_state_nxt = RD_B;
            RD_B:    w_state_nxt = CAP;
            CAP:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Fg_CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_pend      <= 1'b0;
            r_pend_chan <= 1'b0;
            r_pend_word <= '0;
            r_apply     <= 1'b0;
        end else begin
            if (r_state == IDLE && w_strobe) r_apply <= r_pend;
            if (w_acc && r_apply)            r_pend  <= 1'b0;
            if (w_cfg_xfer) begin
                r_pend      <= 1'b1;
                r_pend_chan <= CfgChan;
                r_pend_word <= CfgTuning;
            end
        end
    end

`ifdef DDS_PHASE_SYNC_EN
    logic r_sync_req;

    always_ff @(posedge Fg_CLK or negedge RESETn) begin
        if (!RESETn) r_sync_req <= 1'b0;
        else         r_sync_req <= (r_sync_req & ~w_acc) | PhaseSync;
    end

    assign w_sync = r_sync_req & w_acc;
`else
    assign w_sync = 1'b0;
`endif

    dds_phase_acc #(.PHASE_W(PHASE_W)) u_acc_a (
        .Fg_CLK  (Fg_CLK),
        .RESETn  (RESETn),
        .i_load  (w_load_a),
        .i_tune  (r_pend_word),
        .i_adv   (w_acc),
`ifdef DDS_PHASE_SYNC_EN
        .i_sync  (w_sync),
`endif
        .o_phase (w_phase_a)
    );

    dds_phase_acc #(.PHASE_W(PHASE_W)) u_acc_b (
        .Fg_CLK  (Fg_CLK),
        .RESETn  (RESETn),
        .i_load  (w_load_b),
        .i_tune  (r_pend_word),
        .i_adv   (w_acc),
`ifdef DDS_PHASE_SYNC_EN
        .i_sync  (w_sync),
`endif
        .o_phase (w_phase_b)
    );

    always_comb begin
        LutRd   = 1'b0;
        LutAddr = '0;
        unique case (r_state)
            RD_A: begin
                LutRd   = 1'b1;
                LutAddr = w_phase_a[PHASE_W-1 -: ADDR_W];
            end
            RD_B: begin
                LutRd   = 1'b1;
                LutAddr = w_phase_b[PHASE_W-1 -: ADDR_W];
            end
            default: ;
        endcase
    end

    // LUT data lags the read by one cycle: A arrives in RD_B, B arrives in CAP.
    always_ff @(posedge Fg_CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_shadow <= '0;
            r_cha    <= '0;
            r_chb    <= '0;
            r_sv     <= 1'b0;
            r_ovr    <= 1'b0;
        end else begin
            r_sv <= (r_state == CAP);
            if (r_state == RD_B) r_shadow <= LutData;
            if (r_state == CAP) begin
                r_cha <= r_shadow;
                r_chb <= LutData;
            end
            if (w_strobe && r_state != IDLE) r_ovr <= 1'b1;
            else if (OvrClr)                 r_ovr <= 1'b0;
        end
    end

    assign CfgReady    = ~r_pend;
    assign ChA_Data    = r_cha;
    assign ChB_Data    = r_chb;
    assign SampleValid = r_sv;
    assign Busy        = (r_state != IDLE);
    assign Overrun     = r_ovr;

endmodule

// File: tb/tb_dds_lut_sched.sv
// Bench for dds_lut_sched: sample-level model plus directed vectors with literal expectations.
// Build with DDS_PHASE_SYNC_EN defined to also exercise the phase-sync input.
module tb_dds_lut_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        Ready = 1'b0, Enable = 1'b0;
    logic        CfgValid = 1'b0, CfgChan = 1'b0;
    logic [23:0] CfgTuning = '0;
    logic        OvrClr = 1'b0;
    logic        CfgReady, LutRd, SampleValid, Busy, Overrun;
    logic [7:0]  LutAddr, ChA_Data, ChB_Data;
    logic [7:0]  lut_q = '0;
`ifdef DDS_PHASE_SYNC_EN
    logic        PhaseSync = 1'b0;
`endif

    int n_checks = 0;
    int n_err    = 0;

    dds_lut_sched #(.PHASE_W(24), .ADDR_W(8), .DATA_W(8)) dut (
        .Fg_CLK      (clk),
        .RESETn      (rst_n),
        .Ready       (Ready),
        .Enable      (Enable),
        .CfgValid    (CfgValid),
        .CfgChan     (CfgChan),
        .CfgTuning   (CfgTuning),
        .CfgReady    (CfgReady),
        .OvrClr      (OvrClr),
`ifdef DDS_PHASE_SYNC_EN
        .PhaseSync   (PhaseSync),
`endif
        .LutRd       (LutRd),
        .LutAddr     (LutAddr),
        .LutData     (lut_q),
        .ChA_Data    (ChA_Data),
        .ChB_Data    (ChB_Data),
        .SampleValid (SampleValid),
        .Busy        (Busy),
        .Overrun     (Overrun)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [7:0] lut_f(input logic [7:0] a);
        return 8'(a * 3 + 8'h5A);
    endfunction

    always @(posedge clk) if (LutRd) lut_q <= lut_f(LutAddr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: m_seq counts cycles since an accepted strobe (0 = idle).
    int          m_seq = 0;
    logic [23:0] m_phA = '0, m_phB = '0, m_tuA = '0, m_tuB = '0, m_pword = '0;
    logic        m_pend = 1'b0, m_pchan = 1'b0, m_apply = 1'b0, m_sync = 1'b0;
    logic        m_sv = 1'b0, m_ovr = 1'b0;
    logic [7:0]  m_cha = '0, m_chb = '0;

    task automatic model_step();
        logic strobe, xfer;
        if (!rst_n) begin
            m_seq = 0; m_phA = '0; m_phB = '0; m_tuA = '0; m_tuB = '0; m_pword = '0;
            m_pend = 0; m_pchan = 0; m_apply = 0; m_sync = 0; m_sv = 0; m_ovr = 0;
            m_cha = '0; m_chb = '0;
            return;
        end
        strobe = Ready && Enable;
        xfer   = CfgValid && !m_pend;
        m_sv   = 1'b0;
        if (strobe && m_seq != 0) m_ovr = 1'b1;
        else if (OvrClr)          m_ovr = 1'b0;
        case (m_seq)
            0: if (strobe) begin m_seq = 1; m_apply = m_pend; end
            1: begin
                if (m_apply) begin
                    if (m_pchan) m_tuB = m_pword; else m_tuA = m_pword;
                    m_pend = 1'b0;
                end
                if (m_sync) begin
                    m_phA = m_tuA; m_phB = m_tuB; m_sync = 1'b0;
                end else begin
                    m_phA = m_phA + m_tuA; m_phB = m_phB + m_tuB;
                end
                m_seq = 2;
            end
            2, 3: m_seq++;
            default: begin
                m_seq = 0; m_sv = 1'b1;
                m_cha = lut_f(m_phA[23:16]); m_chb = lut_f(m_phB[23:16]);
            end
        endcase
        if (xfer) begin m_pend = 1'b1; m_pchan = CfgChan; m_pword = CfgTuning; end
`ifdef DDS_PHASE_SYNC_EN
        if (PhaseSync) m_sync = 1'b1;
`endif
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        model_step();
    end

    // Compare every cycle on the falling edge.
    task automatic compare_step();
        logic       exp_rd;
        logic [7:0] exp_addr;
        exp_rd   = (m_seq == 2) || (m_seq == 3);
        exp_addr = (m_seq == 2) ? m_phA[23:16] : (m_seq == 3) ? m_phB[23:16] : 8'h00;
        check("busy",       32'(Busy),        32'(m_seq != 0));
        check("lut_rd",     32'(LutRd),       32'(exp_rd));
        check("lut_addr",   32'(LutAddr),     32'(exp_addr));
        check("sample_vld", 32'(SampleValid), 32'(m_sv));
        check("cha_data",   32'(ChA_Data),    32'(m_cha));
        check("chb_data",   32'(ChB_Data),    32'(m_chb));
        check("cfg_ready",  32'(CfgReady),    32'(!m_pend));
        check("overrun",    32'(Overrun),     32'(m_ovr));
    endtask

    initial forever begin
        @(negedge clk);
        compare_step();
    end

    // Drop CfgValid right after the edge that completes a transfer.
    initial forever begin
        @(posedge clk);
        if (CfgValid && CfgReady) begin
            #1;
            CfgValid = 1'b0;
        end
    end

    task automatic cfg(input logic chan, input logic [23:0] word);
        int i;
        @(negedge clk);
        CfgValid = 1'b1; CfgChan = chan; CfgTuning = word;
        for (i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!CfgValid) break;
        end
        check("cfg_xfer_timeout", 32'(CfgValid), 32'd0);
    endtask

    task automatic do_seq(output logic [7:0] a0, output logic [7:0] a1,
                          output int nrd, output int nbusy, output int lat);
        a0 = '0; a1 = '0; nrd = 0; nbusy = 0; lat = -1;
        @(negedge clk); Ready = 1'b1; Enable = 1'b1;
        @(negedge clk); Enable = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (SampleValid) begin lat = i; break; end
            if (LutRd) begin
                if (nrd == 0) a0 = LutAddr; else a1 = LutAddr;
                nrd++;
            end
            if (Busy) nbusy++;
            @(negedge clk);
        end
        check("seq_latency", 32'(lat), 32'd4);
    endtask

    task automatic wait_sv();
        logic got = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (SampleValid) begin got = 1'b1; break; end
        end
        check("wait_sv_timeout", 32'(got), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
        $fatal(1);
    end

    initial begin
        logic [7:0] a0, a1;
        int         nrd, nbusy, lat, nsv;

        repeat (3) @(negedge clk);
        check("rst_cfg_ready", 32'(CfgReady), 32'd1);
        check("rst_busy",      32'(Busy),     32'd0);
        rst_n = 1'b1;

        // Single strobe from reset: zero tuning reads LUT[0] twice.
        do_seq(a0, a1, nrd, nbusy, lat);
        check("t1_addr_a", 32'(a0), 32'h00);
        check("t1_addr_b", 32'(a1), 32'h00);
        check("t1_nrd",    32'(nrd), 32'd2);
        check("t1_busy",   32'(nbusy), 32'd4);
        check("t1_cha",    32'(ChA_Data), 32'h5A);
        check("t1_chb",    32'(ChB_Data), 32'h5A);

        // Tuning words; B is only accepted once A's slot has been consumed.
        cfg(1'b0, 24'h010000);
        do_seq(a0, a1, nrd, nbusy, lat);
        check("t2_prime_a", 32'(a0), 32'h01);
        check("t2_prime_b", 32'(a1), 32'h00);
        cfg(1'b1, 24'h020000);
        for (int k = 0; k < 3; k++) begin
            do_seq(a0, a1, nrd, nbusy, lat);
            check("t2_addr_a", 32'(a0), 32'(2 + k));
            check("t2_addr_b", 32'(a1), 32'(2 + 2 * k));
            repeat (3) @(negedge clk);
        end
        check("t2_cha", 32'(ChA_Data), 32'h66);
        check("t2_chb", 32'(ChB_Data), 32'h6C);

        // Config accepted on the ACC-entry edge waits a sequence; second offer is blocked.
        @(negedge clk); Enable = 1'b1; CfgValid = 1'b1; CfgChan = 1'b0; CfgTuning = 24'h100000;
        @(negedge clk); Enable = 1'b0;
        check("t3_blocked", 32'(CfgReady), 32'd0);
        CfgValid = 1'b1; CfgChan = 1'b1; CfgTuning = 24'h200000;
        wait_sv();
        check("t3_cha_old", 32'(ChA_Data), 32'h69);
        check("t3_chb_old", 32'(ChB_Data), 32'h72);
        check("t3_still_blocked", 32'(CfgReady), 32'd0);
        do_seq(a0, a1, nrd, nbusy, lat);
        check("t3_addr_a_new", 32'(a0), 32'h15);
        check("t3_addr_b_new", 32'(a1), 32'h0A);
        check("t3_model_tuA",  32'(m_tuA), 32'h100000);
        check("t3_second_pend", 32'(CfgReady), 32'd0);
        repeat (3) @(negedge clk);
        do_seq(a0, a1, nrd, nbusy, lat);
        check("t3_addr_a2", 32'(a0), 32'h25);
        check("t3_addr_b2", 32'(a1), 32'h2A);
        check("t3_free",    32'(CfgReady), 32'd1);

        // Ready falls mid-sequence: sequence completes, held Enable is ignored.
        @(negedge clk); Ready = 1'b1; Enable = 1'b1;
        @(negedge clk); Ready = 1'b0;
        wait_sv();
        check("t4_cha", 32'(ChA_Data), 32'hF9);
        check("t4_chb", 32'(ChB_Data), 32'h38);
        repeat (3) @(negedge clk);
        check("t4_idle", 32'(Busy), 32'd0);
        check("t4_no_ovr", 32'(Overrun), 32'd0);
        Enable = 1'b0; Ready = 1'b1;

        // Enable held: one sequence per 5 cycles, busy-time strobes set Overrun.
        @(negedge clk); Enable = 1'b1;
        nsv = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (SampleValid) nsv++;
        end
        Enable = 1'b0;
        check("t5_nsv",  32'(nsv), 32'd2);
        check("t5_ovr",  32'(Overrun), 32'd1);
        OvrClr = 1'b1;
        @(negedge clk); OvrClr = 1'b0;
        check("t5_ovr_clr", 32'(Overrun), 32'd0);
        Enable = 1'b1;
        @(negedge clk); OvrClr = 1'b1;
        @(negedge clk); Enable = 1'b0; OvrClr = 1'b0;
        check("t5_set_wins", 32'(Overrun), 32'd1);
        wait_sv();
        OvrClr = 1'b1;
        @(negedge clk); OvrClr = 1'b0;

        // Async reset in the middle of a sequence.
        @(negedge clk); Enable = 1'b1;
        @(negedge clk); Enable = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        check("t6_rst_busy",  32'(Busy), 32'd0);
        check("t6_rst_rd",    32'(LutRd), 32'd0);
        check("t6_rst_sv",    32'(SampleValid), 32'd0);
        check("t6_rst_ready", 32'(CfgReady), 32'd1);
        rst_n = 1'b1;

        // Phase wrap with an all-ones tuning word.
        cfg(1'b0, 24'hFFFFFF);
        do_seq(a0, a1, nrd, nbusy, lat);
        check("t7_addr1",  32'(a0), 32'hFF);
        check("t7_phase1", 32'(m_phA), 32'hFFFFFF);
        repeat (3) @(negedge clk);
        do_seq(a0, a1, nrd, nbusy, lat);
        check("t7_addr2",  32'(a0), 32'hFF);
        check("t7_addr2b", 32'(a1), 32'h00);
        check("t7_phase2", 32'(m_phA), 32'hFFFFFE);
        check("t7_cha",    32'(ChA_Data), 32'h57);
        check("t7_chb",    32'(ChB_Data), 32'h5A);

`ifdef DDS_PHASE_SYNC_EN
        cfg(1'b1, 24'h030000);
        do_seq(a0, a1, nrd, nbusy, lat);
        repeat (2) @(negedge clk);
        do_seq(a0, a1, nrd, nbusy, lat);
        @(negedge clk); PhaseSync = 1'b1;
        @(negedge clk); PhaseSync = 1'b0;
        do_seq(a0, a1, nrd, nbusy, lat);
        check("t8_sync_a", 32'(a0), 32'hFF);
        check("t8_sync_b", 32'(a1), 32'h03);
        check("t8_model",  32'(m_phB), 32'h030000);
`endif

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
